// File: rtl/sram_march_tester.sv
// sram_march_tester: autonomous four-phase march test of an async SRAM-style device.
//   Phases: P0 write p(a) ascending, P1 verify ascending, P2 write ~p(a) descending,
//   P3 verify descending. Each access takes WAIT_CYCLES+2 cycles.
//   Optional macro SRAM_MARCH_LFSR_EN enables the 16-bit LFSR pattern for mode 3;
//   without it mode 3 is a solid zero pattern.
// Ports:
//   clk, reset_n (async, active low), start (pulse), mode[1:0] (pattern select)
//   busy, done, pass, err_count[15:0], err_addr/err_exp/err_got (first miscompare)
//   sram_a, sram_dq (inout), sram_ce_n, sram_oe_n, sram_we_n (active-low strobes)
module sram_march_tester #(
  parameter int AW = 21,
  parameter int DW = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [1:0]    mode,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   err_count,
  output logic [AW-1:0] err_addr,
  output logic [DW-1:0] err_exp,
  output logic [DW-1:0] err_got,
  output logic [AW-1:0] sram_a,
  inout  wire  [DW-1:0] sram_dq,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n
);
  typedef enum logic [2:0] {IDLE, WR, WR_HOLD, RD, RD_GAP, DONE} state_t;
  state_t state, state_nx;
  logic [AW-1:0] addr;
  logic [1:0] phase, mode_r;
  logic [3:0] wcnt;
  logic [DW-1:0] rd_q, pat, base, lfsr_pat;
  logic [31:0] sh;
  logic settled, accept, last_beat, last_addr, step, final_acc;
  // A start seen in the very first DONE cycle is dropped; settled marks later DONE cycles.
  assign accept = start && (state == IDLE || (state == DONE && settled));
  assign last_beat = wcnt == 4'(WAIT_CYCLES);
  assign last_addr = phase[1] ? addr == '0 : addr == '1;
  assign step = state == WR_HOLD || state == RD_GAP;
  assign final_acc = state == RD_GAP && last_addr && phase == 2'd3;
  assign busy = !(state == IDLE || state == DONE);
  assign done = state == DONE;
  assign pass = done && err_count == 16'd0;
  assign sram_a = addr;
  assign sram_ce_n = !busy;
  assign sram_we_n = state != WR;
  assign sram_oe_n = state != RD;
  assign sram_dq = (state == WR || state == WR_HOLD) ? pat : 'z;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? WR : IDLE;
      WR:      state_nx = last_beat ? WR_HOLD : WR;
      WR_HOLD: state_nx = last_addr ? RD : WR;
      RD:      state_nx = last_beat ? RD_GAP : RD;
      RD_GAP:  state_nx = !last_addr ? RD : phase == 2'd3 ? DONE : WR;
      DONE:    state_nx = accept ? WR : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // Odd and even phases share p(a); phases 2/3 use its complement.
  always_comb begin
    sh = 32'(addr) % 32'(DW);
    base = mode_r == 2'd0 ? DW'(addr) :
           mode_r == 2'd1 ? (addr[0] ? DW'({DW/2{2'b10}}) : DW'({DW/2{2'b01}})) :
           mode_r == 2'd2 ? DW'(1) << sh : lfsr_pat;
    pat = base ^ {DW{phase[1]}};
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      settled <= 1'b0;
      wcnt <= 4'd0;
      addr <= '0;
      phase <= 2'd0;
      mode_r <= 2'd0;
      rd_q <= '0;
      err_count <= 16'd0;
      err_addr <= '0;
      err_exp <= '0;
      err_got <= '0;
    end else begin
      state <= state_nx;
      settled <= state == DONE;
      wcnt <= ((state == WR || state == RD) && !last_beat) ? wcnt + 4'd1 : 4'd0;
      if (state == RD && last_beat) rd_q <= sram_dq;
      if (accept) begin
        mode_r <= mode;
        phase <= 2'd0;
        addr <= '0;
        err_count <= 16'd0;
        err_addr <= '0;
        err_exp <= '0;
        err_got <= '0;
      end else if (step && !last_addr) begin
        addr <= phase[1] ? addr - AW'(1) : addr + AW'(1);
      end else if (step && !final_acc) begin
        // Next phase starts at 0 for P1, at the top address for P2/P3.
        phase <= phase + 2'd1;
        addr <= phase == 2'd0 ? '0 : '1;
      end
      if (state == RD_GAP && rd_q != pat) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (err_count == 16'd0) begin
          err_addr <= addr;
          err_exp <= pat;
          err_got <= rd_q;
        end
      end
    end
  end
`ifdef SRAM_MARCH_LFSR_EN
  logic [15:0] lfsr;
  assign lfsr_pat = DW'({(DW + 15) / 16{lfsr}});
  // Reloaded per phase so the verify phase replays the write phase sequence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr <= 16'hACE1;
    else if (accept || (step && last_addr)) lfsr <= 16'hACE1;
    else if (step) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end
`else
  assign lfsr_pat = '0;
`endif
endmodule
